// File: rtl/data_dewhiting_pkg.sv
// Shared PN9 whitening definitions: FSM encodings, default seed/header length
// and the PN9 feedback taps, used by both the whitening and de-whitening blocks.
package data_dewhiting_pkg;

  localparam int unsigned HDR_PAD_CYCLES = 80;
  localparam logic [8:0]  PN9_SEED       = 9'h001;

  localparam int unsigned PN9_TAP_A = 5;
  localparam int unsigned PN9_TAP_B = 0;

  typedef enum logic [1:0] {
    WAITING       = 2'd0,
    PADDING       = 2'd1,
    DECODING      = 2'd2,
    RIGHT_PADDING = 2'd3
  } dw_state_e;

  // Right-shifting PN9: feedback enters at bit 8.
  function automatic logic [8:0] pn9_next(input logic [8:0] r);
    return {r[PN9_TAP_A] ^ r[PN9_TAP_B], r[8:1]};
  endfunction

endpackage

// File: rtl/data_dewhiting_pn9_lfsr.sv
// PN9 sequence register: reseeds on reset or load_seed, otherwise advances on step.
module pn9_lfsr
  import data_dewhiting_pkg::*;
#(
  parameter logic [8:0] SEED = PN9_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_seed,
  input  logic       step,
  output logic [8:0] state
);

  always_ff @(posedge clk) begin
    if (reset || load_seed) begin
      state <= SEED;
    end else if (step) begin
      state <= pn9_next(state);
    end
  end

endmodule

// File: rtl/data_dewhiting.sv
// Frame de-whitener: passes an un-whitened header through, then XORs each
// received byte with the PN9 keystream until the closing delimiter.
module data_dewhiting
  import data_dewhiting_pkg::*;
#(
  parameter int unsigned PAD_CYCLES  = HDR_PAD_CYCLES,
  parameter logic [8:0]  RANDOM_INIT = PN9_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       indicator,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       next_indicator
);

  localparam logic [6:0] PAD_LAST = 7'(PAD_CYCLES - 1);

  dw_state_e   state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic [7:0]  dout_p1, dout_d;
  logic        vld_p1, vld_d;
  logic        load_seed, step;
  logic [8:0]  lfsr;
  logic        lfsr_msb_unused;
  logic        slot_end;

  assign slot_end        = (count_q[2:0] == 3'd7);
  assign lfsr_msb_unused = lfsr[8];

  pn9_lfsr #(
    .SEED (RANDOM_INIT)
  ) u_pn9 (
    .clk       (clk),
    .reset     (reset),
    .load_seed (load_seed),
    .step      (step),
    .state     (lfsr)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    dout_d         = dout_p1;
    vld_d          = 1'b0;
    load_seed      = 1'b0;
    step           = 1'b0;
    next_indicator = 1'b0;

    case (state_q)
      WAITING: begin
        load_seed = 1'b1;
        count_d   = '0;
        dout_d    = '0;
        if (indicator) begin
          state_d        = PADDING;
          next_indicator = 1'b1;
        end
      end

      PADDING: begin
        count_d = count_q + 7'd1;
        if (slot_end) begin
          dout_d = din;
          vld_d  = 1'b1;
        end
        // The keystream starts one step past the seed on entry to DECODING.
        if (count_q == PAD_LAST) begin
          state_d = DECODING;
          count_d = '0;
          step    = 1'b1;
        end else begin
          load_seed = 1'b1;
        end
      end

      DECODING: begin
        step    = 1'b1;
        count_d = count_q + 7'd1;
        if (slot_end) begin
          dout_d = din ^ lfsr[7:0];
          vld_d  = 1'b1;
        end
        if (indicator) begin
          state_d = RIGHT_PADDING;
          count_d = '0;
        end
      end

      RIGHT_PADDING: begin
        step    = 1'b1;
        count_d = count_q + 7'd1;
        if (count_q == 7'd7) begin
          state_d        = WAITING;
          count_d        = '0;
          dout_d         = '0;
          load_seed      = 1'b1;
          step           = 1'b0;
          next_indicator = 1'b1;
        end
      end

      default: begin
        state_d   = WAITING;
        count_d   = '0;
        dout_d    = '0;
        load_seed = 1'b1;
      end
    endcase

    if (reset) next_indicator = 1'b0;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAITING;
      count_q <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_p1 <= dout_d;
      vld_p1  <= vld_d;
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;

endmodule

// File: tb/tb_data_dewhiting.sv
// Directed bench for data_dewhiting: header pass-through, first key, 64-byte
// whitened payload, frame end and mid-frame abort.
module tb_data_dewhiting;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       indicator;
  logic [7:0] dout;
  logic       dout_valid;
  logic       next_indicator;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] m;
  logic [7:0] src;
  logic [7:0] key;
  int         dv_cnt;

  data_dewhiting dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .indicator      (indicator),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .next_indicator (next_indicator)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] pn9(input logic [8:0] r);
    return {r[5] ^ r[0], r[8:1]};
  endfunction

  // Key used at the end of the slot starting with model state r.
  function automatic logic [7:0] key_of(input logic [8:0] r);
    logic [8:0] t;
    t = r;
    for (int i = 0; i < 7; i++) t = pn9(t);
    return t[7:0];
  endfunction

  task automatic decode_slot(input logic [7:0] wdin, input logic end_frame);
    for (int k = 0; k < 8; k++) begin
      din       = wdin;
      indicator = end_frame && (k == 7);
      m         = pn9(m);
      tick();
    end
    indicator = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] hdr);
    indicator = 1'b1;
    din       = hdr;
    tick();
    indicator = 1'b0;
    repeat (80) tick();
    m = 9'h100;
  endtask

  initial begin
    reset     = 1'b1;
    indicator = 1'b1;
    din       = 8'h00;
    #1;
    chk("rst_next_ind", next_indicator, 1'b0);
    tick();
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_dv", dout_valid, 1'b0);
    chk("rst_next_ind2", next_indicator, 1'b0);

    // Header window
    reset     = 1'b0;
    indicator = 1'b1;
    din       = 8'hA5;
    #1;
    chk("hdr_next_ind", next_indicator, 1'b1);
    tick();
    indicator = 1'b0;
    dv_cnt    = 0;
    for (int i = 0; i < 80; i++) begin
      indicator = (i == 20);
      if (i == 20) begin
        #1;
        chk("pad_ind_ignored", next_indicator, 1'b0);
      end
      tick();
      indicator = 1'b0;
      if (dout_valid) dv_cnt++;
      if (i == 7) chk("hdr_first_slot", dout, 8'hA5);
    end
    chk("hdr_dv_count", dv_cnt, 10);

    // First key
    m = 9'h100;
    decode_slot(8'h22, 1'b0);
    chk("first_key_dout", dout, 8'h00);
    chk("first_key_dv", dout_valid, 1'b1);

    // Whitened payload
    for (int b = 0; b < 64; b++) begin
      src = 8'($urandom);
      key = key_of(m);
      decode_slot(src ^ key, 1'b0);
      chk($sformatf("loop_byte%0d", b), dout, src);
    end

    // Frame end on a slot boundary: last byte still decoded
    src = 8'h5E;
    key = key_of(m);
    decode_slot(src ^ key, 1'b1);
    chk("end_last_byte", dout, src);
    chk("end_last_dv", dout_valid, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("end_hold_ni%0d", k), next_indicator, 1'b0);
      tick();
      chk($sformatf("end_hold_dout%0d", k), dout, src);
    end
    chk("end_next_ind", next_indicator, 1'b1);
    tick();
    chk("end_dout_clr", dout, 8'h00);
    chk("end_next_ind_off", next_indicator, 1'b0);
    chk("end_dv", dout_valid, 1'b0);

    // Abort mid-frame at DECODING count 37
    start_frame(8'h3C);
    repeat (37) tick();
    reset = 1'b1;
    tick();
    chk("abort_dout", dout, 8'h00);
    chk("abort_dv", dout_valid, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    chk("abort_idle_dv", dout_valid, 1'b0);
    start_frame(8'h3C);
    decode_slot(8'h22, 1'b0);
    chk("abort_first_key", dout, 8'h00);
    chk("abort_first_dv", dout_valid, 1'b1);
    tick();
    chk("abort_dv_strobe", dout_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
